// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative RV32M multiply/divide unit, one bit per cycle
// Optional macro MDU_FAST_MUL_EN: single-cycle registered multiplier for MUL/MULH/MULHSU/MULHU.
module mdu_iterative #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [RD_W-1:0] rd_in,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [2*XLEN-1:0] acc;      // mul: {partial_hi, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   divisor;  // multiplicand magnitude for mul, divisor magnitude for div
    logic [CW-1:0]     count;
    logic [2:0]        f3_q;
    logic              neg_q;
    logic              neg_r;
    logic [RD_W-1:0]   rd_q;

    logic            sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] fast_res;

    assign busy  = (state != IDLE);
    assign stall = (start && state == IDLE) || (state != IDLE && !done);

    // Signedness per op: MUL/MULH/DIV/REM both, MULHSU only rs1, unsigned ops none.
    always_comb begin
        sa       = 1'b0;
        sb       = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sa = op_a[XLEN-1];
                sb = op_b[XLEN-1];
            end
            3'b010:  sa = op_a[XLEN-1];
            default: ;
        endcase
        mag_a    = sa ? (~op_a + 1'b1) : op_a;
        mag_b    = sb ? (~op_b + 1'b1) : op_b;
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN_VAL) && (op_b == '1);
        if (div_zero)
            fast_res = funct3[1] ? op_a : '1;
        else
            fast_res = funct3[1] ? '0 : MIN_VAL;
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] acc_nx;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, divisor};
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift[XLEN-1:0] - divisor;
        acc_nx    = '0;
        if (f3_q[2]) begin
            if (div_shift >= {1'b0, divisor})
                acc_nx = {div_diff, acc[XLEN-2:0], 1'b1};
            else
                acc_nx = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_nx = {mul_sum, acc[XLEN-1:1]};
            else
                acc_nx = {1'b0, acc[2*XLEN-1:1]};
        end
    end

    function automatic logic [XLEN-1:0] fixup(input logic [2:0] f3, input logic nq,
                                               input logic nr, input logic [2*XLEN-1:0] v);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q, r;
        p = nq ? (~v + 1'b1) : v;
        q = nq ? (~v[XLEN-1:0] + 1'b1) : v[XLEN-1:0];
        r = nr ? (~v[2*XLEN-1:XLEN] + 1'b1) : v[2*XLEN-1:XLEN];
        if (!f3[2])
            fixup = (f3[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        else
            fixup = f3[1] ? r : q;
    endfunction

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            divisor <= '0;
            count   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rd_q    <= '0;
            done    <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        f3_q    <= funct3;
                        neg_q   <= sa ^ sb;
                        neg_r   <= sa;
                        rd_q    <= rd_in;
                        count   <= '0;
                        divisor <= mag_b;
                        acc     <= {{XLEN{1'b0}}, mag_a};
                        if (div_zero || div_ovf) begin
                            result <= fast_res;
                            rd_out <= rd_in;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
`ifdef MDU_FAST_MUL_EN
                        else if (!funct3[2]) begin
                            result <= fixup(funct3, sa ^ sb, sa, fast_prod);
                            rd_out <= rd_in;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
`endif
                        else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc   <= acc_nx;
                        count <= count + 1'b1;
                        if (count == CW'(XLEN-1)) begin
                            result <= fixup(f3_q, neg_q, neg_r, acc_nx);
                            rd_out <= rd_q;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
